// File: rtl/pipe_pkg.sv
// Shared types and constants for the inter-stage pipeline buffer.
// Optional stall counter in the top is enabled by PIPE_BUF_STALL_CNT_EN.
package pipe_pkg;

   // Occupancy of the buffer. 2'b11 is unreachable and decodes as EMPTY.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b10
   } buf_state_t;

   // Bubble instruction word for a 16-bit processor stage payload.
   localparam logic [15:0] PIPE_NOP_INSN = 16'h0000;

endpackage

// File: rtl/pipe_data_reg.sv
// W-bit payload register: async active-low reset to RST_VAL,
// synchronous clear to RST_VAL (wins over load), synchronous load.
module pipe_data_reg #(
   parameter int unsigned    W       = 16,
   parameter logic [W-1:0]   RST_VAL = {W{1'b0}}
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_clear,
   input  logic         i_load,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   // Hold, clear to the bubble value, or capture new data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_q <= RST_VAL;
      end else if (i_clear) begin
         r_q <= RST_VAL;
      end else if (i_load) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_buffer.sv
// Two-entry valid/ready pipeline buffer with synchronous flush.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; valid may rise without waiting for ready and the payload is held
// by the sender until it transfers. in_ready and out_valid come straight
// from state flops, so out_ready never reaches in_ready combinationally.
// Optional stall counter: define PIPE_BUF_STALL_CNT_EN.
module pipe_skid_buffer
   import pipe_pkg::*;
#(
   parameter int unsigned  W         = 16,
   parameter logic [W-1:0] NOP_VALUE = {W{1'b0}},
   parameter int unsigned  CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
`ifdef PIPE_BUF_STALL_CNT_EN
   output logic [CNT_W-1:0] stall_cnt,
`endif
   output buf_state_t       o_dbg_state
);

   buf_state_t   r_state;
   buf_state_t   w_next;
   logic         w_in_fire;
   logic         w_out_fire;
   logic         w_main_load;
   logic         w_main_from_skid;
   logic         w_skid_load;
   logic [W-1:0] w_main_d;
   logic [W-1:0] w_skid_q;

   assign w_in_fire  = in_valid & in_ready;
   assign w_out_fire = out_valid & out_ready;
   assign w_main_d   = w_main_from_skid ? w_skid_q : in_data;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state and register load enables; flush overrides everything.
   always_comb begin
      w_next           = r_state;
      w_main_load      = 1'b0;
      w_main_from_skid = 1'b0;
      w_skid_load      = 1'b0;
      case (r_state)
         ONE: begin
            if (w_in_fire && w_out_fire) begin
               w_main_load = 1'b1;
            end else if (w_in_fire) begin
               w_next      = FULL;
               w_skid_load = 1'b1;
            end else if (w_out_fire) begin
               w_next = EMPTY;
            end
         end
         FULL: begin
            if (w_out_fire) begin
               w_next           = ONE;
               w_main_load      = 1'b1;
               w_main_from_skid = 1'b1;
            end
         end
         default: begin
            // EMPTY and the illegal encoding behave identically.
            if (w_in_fire) begin
               w_next      = ONE;
               w_main_load = 1'b1;
            end else begin
               w_next = EMPTY;
            end
         end
      endcase
      if (flush) begin
         w_next           = EMPTY;
         w_main_load      = 1'b0;
         w_main_from_skid = 1'b0;
         w_skid_load      = 1'b0;
      end
   end

   // Handshake outputs decoded from the state flops only.
   always_comb begin
      out_valid   = (r_state == ONE) || (r_state == FULL);
      in_ready    = (r_state != FULL);
      o_dbg_state = r_state;
   end

   pipe_data_reg #(.W(W), .RST_VAL(NOP_VALUE)) u_main (
      .clk     (clk),
      .rst     (rst),
      .i_clear (flush),
      .i_load  (w_main_load),
      .i_d     (w_main_d),
      .o_q     (out_data)
   );

   pipe_data_reg #(.W(W), .RST_VAL(NOP_VALUE)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .i_clear (flush),
      .i_load  (w_skid_load),
      .i_d     (in_data),
      .o_q     (w_skid_q)
   );

`ifdef PIPE_BUF_STALL_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt;

   // Count cycles where a live head is refused; saturate, survive flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt <= {CNT_W{1'b0}};
      end else if (out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Self-checking bench for pipe_skid_buffer: directed scenarios followed by
// randomized traffic, checked against a 2-deep FIFO reference model.
module tb_pipe_skid_buffer;
   import pipe_pkg::*;

   localparam int unsigned  W   = 16;
   localparam logic [W-1:0] NOP = 16'h0000;
`ifdef PIPE_BUF_STALL_CNT_EN
   localparam int unsigned  CNT_W = 4;
`else
   localparam int unsigned  CNT_W = 16;
`endif
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_data;
   buf_state_t   dbg_state;
`ifdef PIPE_BUF_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt;
`endif

   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   int           pops = 0;
   bit           beef_seen = 1'b0;
   bit           model_nop = 1'b1;
   int           m_cnt = 0;
   logic [W-1:0] exp_q[$];

   pipe_skid_buffer #(.W(W), .NOP_VALUE(NOP), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
`ifdef PIPE_BUF_STALL_CNT_EN
      .stall_cnt   (stall_cnt),
`endif
      .o_dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h cycle=%0d", name, act, exp, cyc);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
   endtask

   task automatic send(input logic [W-1:0] d);
      bit fired;
      int n;
      fired    = 1'b0;
      n        = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!fired && n < 64) begin
         @(negedge clk);
         fired = in_ready;
         tick();
         n++;
      end
      check("send_accept", {31'd0, fired}, 32'd1);
   endtask

   // ---------------- scoreboard / monitor ----------------
   // Reference: a FIFO of capacity 2. Inputs/outputs are stable at negedge,
   // so the values seen here are exactly those the next rising edge uses.
   always @(negedge clk) begin
      int sz;
      if (!rst) begin
         exp_q.delete();
         model_nop = 1'b1;
         m_cnt     = 0;
`ifdef PIPE_BUF_STALL_CNT_EN
         check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
      end else begin
         sz = exp_q.size();
         check("in_ready", {31'd0, in_ready}, {31'd0, sz < 2});
         check("out_valid", {31'd0, out_valid}, {31'd0, sz > 0});
         if (sz > 0) begin
            check("out_data", 32'(out_data), 32'(exp_q[0]));
         end else if (model_nop) begin
            check("bubble_data", 32'(out_data), 32'(NOP));
         end
         if (out_valid && out_data == 16'hBEEF) beef_seen = 1'b1;
`ifdef PIPE_BUF_STALL_CNT_EN
         check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
         if (sz > 0 && !out_ready && m_cnt < CNT_MAX) m_cnt++;
`endif
         if (sz > 0 && out_ready) begin
            void'(exp_q.pop_front());
            pops++;
         end
         if (flush) begin
            exp_q.delete();
            model_nop = 1'b1;
         end else if (in_valid && sz < 2) begin
            exp_q.push_back(in_data);
            model_nop = 1'b0;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int t0;
      int p0;
      bit fired;
      bit was_flush;

      // Reset then single transfer.
      do_reset();
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", 32'(out_data), 32'(NOP));
      out_ready = 1'b1;
      send(16'h1234);
      in_valid = 1'b0;
      check("single_valid", {31'd0, out_valid}, 32'd1);
      check("single_data", 32'(out_data), 32'h1234);
      tick();
      check("single_drained", {31'd0, out_valid}, 32'd0);

      // Backpressure fill, then drain in order.
      out_ready = 1'b0;
      send(16'hA001);
      send(16'hA002);
      in_valid = 1'b1;
      in_data  = 16'hA003;
      repeat (3) tick();
      check("fill_in_ready", {31'd0, in_ready}, 32'd0);
      check("fill_state", 32'(dbg_state), 32'(FULL));
      check("fill_head", 32'(out_data), 32'hA001);
      p0 = pops;
      out_ready = 1'b1;
      send(16'hA003);
      in_valid = 1'b0;
      repeat (4) tick();
      check("fill_pops", 32'(pops - p0), 32'd3);
      check("fill_empty", {31'd0, out_valid}, 32'd0);

      // Streaming at one word per cycle.
      t0 = cyc;
      p0 = pops;
      for (int i = 0; i < 8; i++) send(16'(i));
      in_valid = 1'b0;
      check("stream_cycles", 32'(cyc - t0), 32'd8);
      repeat (2) tick();
      check("stream_pops", 32'(pops - p0), 32'd8);

      // Flush while FULL with a competing input.
      out_ready = 1'b0;
      send(16'h0011);
      send(16'h0022);
      in_valid = 1'b1;
      in_data  = 16'hBEEF;
      flush    = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_valid", {31'd0, out_valid}, 32'd0);
      check("flush_data", 32'(out_data), 32'(NOP));
      check("flush_in_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b1;
      repeat (3) tick();
      check("flush_no_beef", {31'd0, beef_seen}, 32'd0);

      // Asynchronous reset while FULL, observed before the next edge.
      out_ready = 1'b0;
      send(16'h0033);
      send(16'h0044);
      in_valid = 1'b0;
      check("areset_pre_full", 32'(dbg_state), 32'(FULL));
      rst = 1'b0;
      #1;
      check("areset_valid", {31'd0, out_valid}, 32'd0);
      check("areset_in_ready", {31'd0, in_ready}, 32'd1);
      check("areset_data", 32'(out_data), 32'(NOP));
      repeat (2) tick();
      rst = 1'b1;

`ifdef PIPE_BUF_STALL_CNT_EN
      // Stall counter saturation and flush immunity.
      out_ready = 1'b0;
      send(16'h0055);
      in_valid = 1'b0;
      repeat (20) tick();
      check("stall_saturated", 32'(stall_cnt), 32'd15);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("stall_after_flush", 32'(stall_cnt), 32'd15);
`endif

      // Randomized traffic; an unaccepted word is held until it transfers.
      flush = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         fired     = in_valid && in_ready;
         was_flush = flush;
         tick();
         if (!in_valid || fired || was_flush) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 16'($urandom_range(0, 16'hFFFF));
         end
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 31) == 0);
      end
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (5) tick();
      check("random_drained", 32'(exp_q.size()), 32'd0);
      check("random_idle", {31'd0, out_valid}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_skid_buffer.md
Name: pipe_skid_buffer

Overview:
- Parametrised next-generation inter-stage pipeline buffer, e.g. IF/ID, ID/EX, EX/MEM, MEM/WB.
- Replaces the plain enable-only stage register with a valid/ready handshake, a 2-entry skid and synchronous flush that inserts a bubble.
- Sustains 1 transfer/cycle. in_ready is fully registered, breaking the combinational stall path between stages.

Parameters:
- W, 16: width of the stage payload in bits.
- NOP_VALUE, {W{1'b0}}: payload value loaded on reset and on flush; the bubble seen downstream.
- CNT_W, 16: stall counter width. Used only when PIPE_BUF_STALL_CNT_EN is defined.

Ports:
- clk  input  1  stage clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous kill of all held entries, active high.
- in_valid  input  1  upstream presents in_data.
- in_ready  output  1  buffer can accept; registered.
- in_data  input  W  upstream payload.
- out_valid  output  1  out_data is a live entry.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  W  head payload; equals NOP_VALUE whenever out_valid=0 after a reset or flush.
- stall_cnt  output  CNT_W  present only with PIPE_BUF_STALL_CNT_EN.

Behaviour:
- Fire rules:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_valid may be asserted independently of in_ready. Data is held by the upstream until it fires.
- Storage: main register (drives out_data) and skid register.
- State machine: EMPTY, ONE, FULL.
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL).
  - Both are decoded from state flops; there is no combinational path from out_ready to in_ready.
- Transitions (no flush):
  - EMPTY: in_fire -> ONE, main <= in_data. Otherwise stay.
  - ONE, in_fire & out_fire: stay ONE, main <= in_data.
  - ONE, in_fire & !out_fire: -> FULL, skid <= in_data, main held.
  - ONE, !in_fire & out_fire: -> EMPTY, main held.
  - ONE, neither: hold.
  - FULL (in_ready=0): out_fire -> ONE, main <= skid. Otherwise hold.
- Latency: in_fire at edge N gives out_valid with that payload in the cycle after edge N.
- Ordering: strict FIFO. The skid entry is never bypassed by new input.
- Flush:
  - Synchronous and highest priority: state <= EMPTY, main <= NOP_VALUE, skid <= NOP_VALUE.
  - An in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle still completes downstream; the buffer does not re-present it.
- Reset, asserted (rst=0) at any time including mid-transfer:
  - Immediately: state=EMPTY, main=skid=NOP_VALUE, out_valid=0, in_ready=1, stall_cnt=0.
  - Deassertion is assumed synchronised externally.
- Boundary conditions:
  - FULL with in_valid=1 and out_ready=0: nothing changes, no data lost.
  - FULL with out_fire: input is not accepted in that same cycle; in_ready rises the next cycle.
- Back-to-back: with out_ready held 1, state stays in EMPTY/ONE and throughput is 1/cycle.

Optional Feature:
- Macro: PIPE_BUF_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt[CNT_W-1:0], counting cycles with out_valid=1 & out_ready=0.
  - Saturates at all-ones and does not wrap.
  - Cleared by reset only; flush does not clear it.
- Undefined: port and counter logic are absent. All other behaviour is identical.

Decomposition:
- Package pipe_pkg:
  - buf_state_t enum: EMPTY=2'b00, ONE=2'b01, FULL=2'b10.
  - 2'b11 is illegal and is treated as EMPTY.
  - Default NOP constant for the processor's instruction word.
- Sub-module pipe_data_reg:
  - W-bit register with async active-low reset to a parameter value, plus synchronous load and synchronous clear-to-NOP.
  - Instantiated twice, for main and skid.

Test Plan:
- Reset then single transfer: pulse rst=0, release; in_valid=1, in_data=16'h1234 for one cycle, out_ready=1 -> in_ready=1 after reset; out_valid=1, out_data=16'h1234 one cycle after the fire, then out_valid=0.
- Backpressure fill: out_ready=0, send 16'hA001 then 16'hA002 -> state FULL, in_ready=0; 16'hA003 held upstream. Raise out_ready -> outputs A001, A002, A003 in order, no loss or duplication.
- Streaming: out_ready=1 constantly, 8 consecutive words 0..7 -> 8 outputs on 8 consecutive cycles, in_ready never drops.
- Flush in FULL with in_valid=1, in_data=16'hBEEF -> next cycle out_valid=0, out_data=NOP_VALUE, in_ready=1; BEEF never appears.
- Async reset mid-stream while FULL (rst low between edges) -> out_valid=0, in_ready=1 immediately, before the next clk edge.
- With PIPE_BUF_STALL_CNT_EN and CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 (saturated); a flush leaves it at 15.
